wave_table_reader: RTL and testbench

WAVE_TABLE_READER -- requirements
Module: wave_table_reader

---
 rtl/wave_table_reader.sv | 168 ++++++++++++++++
 tb/tb_wave_table_reader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/wave_table_reader.sv
// Wavetable oscillator reader: phase accumulator, table fetch, then linear interpolation
// within each of two octave banks and a crossfade between them.
module wave_table_reader (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                sampleTick,
    input  logic                noteOn,
    input  logic [31:0]         phaseInc,
    input  logic [7:0]          octaveIn,
    input  logic [7:0]          xfade,
    output logic [11:0]         sampAddrA,
    output logic                readEn,
    output logic [7:0]          octave,
    input  logic signed [15:0]  interp0,
    input  logic signed [15:0]  interp1,
    input  logic signed [15:0]  anti0,
    input  logic signed [15:0]  anti1,
    output logic signed [15:0]  sampleOut,
    output logic                sampleValid,
    output logic                busy,
    output logic                overrun
);

    localparam int unsigned PHASE_W = 32;
    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned FRAC_W  = 12;
    localparam int unsigned SAMP_W  = 16;
    localparam int unsigned DIFF_W  = SAMP_W + 1;
    localparam int unsigned XF_W    = 8;
    localparam int unsigned PI_W    = 30;
    localparam int unsigned PM_W    = 26;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        INTERP = 3'd3,
        MIX    = 3'd4,
        OUT    = 3'd5
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_accept;

    logic [PHASE_W-1:0]       r_phase;
    logic [FRAC_W-1:0]        r_frac;
    logic [XF_W-1:0]          r_xfade;
    logic signed [SAMP_W-1:0] r_a0, r_b0, r_a1, r_b1;
    logic signed [SAMP_W-1:0] r_s0, r_s1;

    logic signed [DIFF_W-1:0] w_d0, w_d1, w_dm;
    logic signed [PI_W-1:0]   w_p0, w_p1;
    logic signed [PM_W-1:0]   w_pm;
    logic signed [SAMP_W-1:0] w_s0, w_s1, w_y;

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: a tick is accepted only from IDLE
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (sampleTick) begin
                    w_next   = ISSUE;
                    w_accept = 1'b1;
                end
            end
            ISSUE:   w_next = WAIT;
            WAIT:    w_next = INTERP;
            INTERP:  w_next = MIX;
            MIX:     w_next = OUT;
            OUT:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Per-bank interpolation and crossfade; all differences are 17-bit signed, weights zero-extended
    always_comb begin
        w_d0 = {r_b0[SAMP_W-1], r_b0} - {r_a0[SAMP_W-1], r_a0};
        w_d1 = {r_b1[SAMP_W-1], r_b1} - {r_a1[SAMP_W-1], r_a1};
        w_p0 = PI_W'(w_d0) * PI_W'($signed({1'b0, r_frac}));
        w_p1 = PI_W'(w_d1) * PI_W'($signed({1'b0, r_frac}));
        w_s0 = r_a0 + SAMP_W'(w_p0 >>> FRAC_W);
        w_s1 = r_a1 + SAMP_W'(w_p1 >>> FRAC_W);
        w_dm = {r_s1[SAMP_W-1], r_s1} - {r_s0[SAMP_W-1], r_s0};
        w_pm = PM_W'(w_dm) * PM_W'($signed({1'b0, r_xfade}));
        w_y  = r_s0 + SAMP_W'(w_pm >>> XF_W);
    end

    // Datapath and registered outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_phase     <= '0;
            r_frac      <= '0;
            r_xfade     <= '0;
            r_a0        <= '0;
            r_b0        <= '0;
            r_a1        <= '0;
            r_b1        <= '0;
            r_s0        <= '0;
            r_s1        <= '0;
            sampAddrA   <= '0;
            readEn      <= 1'b0;
            octave      <= '0;
            sampleOut   <= '0;
            sampleValid <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            // noteOn wins over the increment; the accepted tick still sees the old phase
            if (noteOn) begin
                r_phase <= '0;
            end else if (w_accept) begin
                r_phase <= r_phase + phaseInc;
            end

            if (w_accept) begin
                sampAddrA <= r_phase[PHASE_W-1 -: ADDR_W];
                r_frac    <= r_phase[PHASE_W-ADDR_W-1 -: FRAC_W];
                octave    <= octaveIn;
                r_xfade   <= xfade;
            end

            readEn <= w_accept && (octaveIn != 8'd0);

            if (sampleTick && (r_state != IDLE)) begin
                overrun <= 1'b1;
            end

            // Table data arrives one cycle after the read; a skipped read yields silence
            if (r_state == WAIT) begin
                if (octave != 8'd0) begin
                    r_a0 <= interp0;
                    r_b0 <= anti0;
                    r_a1 <= interp1;
                    r_b1 <= anti1;
                end else begin
                    r_a0 <= '0;
                    r_b0 <= '0;
                    r_a1 <= '0;
                    r_b1 <= '0;
                end
            end

            if (r_state == INTERP) begin
                r_s0 <= w_s0;
                r_s1 <= w_s1;
            end

            if (r_state == MIX) begin
                sampleOut <= w_y;
            end

            sampleValid <= (r_state == MIX);
            busy        <= (w_next != IDLE);
        end
    end

endmodule

// File: tb/tb_wave_table_reader.sv
// Directed bench for wave_table_reader: expected samples are queued per tick and
// compared when sampleValid pulses.
module tb_wave_table_reader;

    logic               Clk;
    logic               Reset;
    logic               sampleTick;
    logic               noteOn;
    logic [31:0]        phaseInc;
    logic [7:0]         octaveIn;
    logic [7:0]         xfade;
    logic [11:0]        sampAddrA;
    logic               readEn;
    logic [7:0]         octave;
    logic signed [15:0] interp0;
    logic signed [15:0] interp1;
    logic signed [15:0] anti0;
    logic signed [15:0] anti1;
    logic signed [15:0] sampleOut;
    logic               sampleValid;
    logic               busy;
    logic               overrun;

    int total = 0;
    int bad   = 0;
    logic signed [15:0] exp_q[$];
    logic [31:0]        tb_phase;

    wave_table_reader dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .sampleTick  (sampleTick),
        .noteOn      (noteOn),
        .phaseInc    (phaseInc),
        .octaveIn    (octaveIn),
        .xfade       (xfade),
        .sampAddrA   (sampAddrA),
        .readEn      (readEn),
        .octave      (octave),
        .interp0     (interp0),
        .interp1     (interp1),
        .anti0       (anti0),
        .anti1       (anti1),
        .sampleOut   (sampleOut),
        .sampleValid (sampleValid),
        .busy        (busy),
        .overrun     (overrun)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int lerp(input int a, input int b, input int w, input int sh);
        int p;
        p = (b - a) * w;
        // floor division by 2^sh, independent of operator rounding
        if (p >= 0) return a + p / (1 << sh);
        return a - ((-p + (1 << sh) - 1) / (1 << sh));
    endfunction

    // Scoreboard: every output pulse must match the oldest queued expectation
    always @(negedge Clk) begin
        if (sampleValid === 1'b1) begin
            if (exp_q.size() == 0) chk("spurious_valid", 32'(sampleValid), 32'd0);
            else chk("sampleOut", 32'(sampleOut), 32'(exp_q.pop_front()));
        end
    end

    task automatic note_on();
        noteOn = 1'b1;
        @(negedge Clk);
        noteOn = 1'b0;
        tb_phase = 32'd0;
    endtask

    task automatic do_tick(input logic [7:0] oct, input logic [7:0] xf,
                           input int a0, input int b0, input int a1, input int b1,
                           input bit extra);
        logic [11:0] ea;
        int f;
        int y;
        octaveIn = oct;
        xfade    = xf;
        interp0  = 16'(a0);
        anti0    = 16'(b0);
        interp1  = 16'(a1);
        anti1    = 16'(b1);
        ea = tb_phase[31:20];
        f  = int'(tb_phase[19:8]);
        if (oct == 8'd0) y = 0;
        else y = lerp(lerp(a0, b0, f, 12), lerp(a1, b1, f, 12), int'(xf), 8);
        exp_q.push_back(16'(y));
        tb_phase = tb_phase + phaseInc;
        sampleTick = 1'b1;
        @(negedge Clk);
        sampleTick = 1'b0;
        chk("readEn_t1", 32'(readEn), 32'(oct != 8'd0));
        chk("addr_t1", 32'(sampAddrA), 32'(ea));
        chk("octave_t1", 32'(octave), 32'(oct));
        chk("busy_t1", 32'(busy), 32'd1);
        @(negedge Clk);
        chk("readEn_t2", 32'(readEn), 32'd0);
        if (extra) sampleTick = 1'b1;
        @(negedge Clk);
        sampleTick = 1'b0;
        if (extra) chk("overrun_set", 32'(overrun), 32'd1);
        @(negedge Clk);
        chk("valid_t4", 32'(sampleValid), 32'd0);
        @(negedge Clk);
        chk("valid_t5", 32'(sampleValid), 32'd1);
        @(negedge Clk);
        chk("busy_t6", 32'(busy), 32'd0);
        chk("valid_t6", 32'(sampleValid), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_valid"}, 32'(sampleValid), 32'd0);
        chk({tag, "_readEn"}, 32'(readEn), 32'd0);
        chk({tag, "_addr"}, 32'(sampAddrA), 32'd0);
        chk({tag, "_octave"}, 32'(octave), 32'd0);
        chk({tag, "_out"}, 32'(sampleOut), 32'd0);
        chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        Reset = 1'b1; sampleTick = 1'b0; noteOn = 1'b0; phaseInc = '0;
        octaveIn = '0; xfade = '0; interp0 = '0; interp1 = '0; anti0 = '0; anti1 = '0;
        tb_phase = 32'd0;
        repeat (3) @(negedge Clk);
        chk_all_zero("reset");
        Reset = 1'b0;
        @(negedge Clk);

        // Integer step: address advances by one per tick, no fractional part
        phaseInc = 32'h0010_0000;
        note_on();
        do_tick(8'h01, 8'd0, 100, 200, 0, 0, 1'b0);
        do_tick(8'h01, 8'd0, 100, 200, 0, 0, 1'b0);

        // Half step: midpoint interpolation, positive and negative slopes, floor rounding
        phaseInc = 32'h0008_0000;
        note_on();
        do_tick(8'h01, 8'd0, 0, 1000, 0, 0, 1'b0);
        do_tick(8'h01, 8'd0, 0, 1000, 0, 0, 1'b0);
        note_on();
        do_tick(8'h04, 8'd0, 0, -1000, 0, 0, 1'b0);
        do_tick(8'h04, 8'd0, 0, -1000, 0, 0, 1'b0);
        do_tick(8'h04, 8'd0, 0, -999, 0, 0, 1'b0);
        do_tick(8'h04, 8'd0, 0, -999, 0, 0, 1'b0);

        // Address wrap across the top of the table
        phaseInc = 32'hFFF0_0000;
        note_on();
        do_tick(8'h01, 8'd255, 100, 100, -100, -100, 1'b0);
        phaseInc = 32'h0010_0000;
        do_tick(8'h01, 8'd255, 100, 100, -100, -100, 1'b0);
        do_tick(8'h01, 8'd255, 100, 100, -100, -100, 1'b0);

        // Crossfade midpoint and the silent (no bank) case
        do_tick(8'h02, 8'd128, 0, 0, 256, 256, 1'b0);
        do_tick(8'h00, 8'd128, 1000, 2000, 3000, 4000, 1'b0);

        // Tick during an active fetch is dropped and latches overrun
        do_tick(8'h80, 8'd64, -300, 700, 1200, -800, 1'b1);
        chk("overrun_sticky1", 32'(overrun), 32'd1);
        do_tick(8'h80, 8'd64, -300, 700, 1200, -800, 1'b0);
        note_on();
        chk("overrun_sticky2", 32'(overrun), 32'd1);

        // Reset in the middle of a fetch abandons it without a sample
        octaveIn = 8'h01;
        sampleTick = 1'b1;
        @(negedge Clk);
        sampleTick = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk_all_zero("midwait");
        Reset = 1'b0;
        tb_phase = 32'd0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            chk("no_valid_after_reset", 32'(sampleValid), 32'd0);
        end
        do_tick(8'h01, 8'd0, 5, 5, 0, 0, 1'b0);

        @(negedge Clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
